// File: rtl/packet_queue_p_pkg.sv
// Shared constants and types for the packet queue: default geometry,
// packet field offsets and the output-stage fill source.
package packet_queue_p_pkg;

    localparam int unsigned PQ_PACKET_WIDTH = 175;
    localparam int unsigned PQ_DEPTH_LOG2   = 10;
    localparam int unsigned PQ_AFULL_MARGIN = 4;

    // Packet field offsets on the ring
    localparam int unsigned PKT_TAG_LSB  = 0;
    localparam int unsigned PKT_TAG_W    = 16;
    localparam int unsigned PKT_DEST_LSB = PKT_TAG_LSB + PKT_TAG_W;
    localparam int unsigned PKT_DEST_W   = 8;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RAM,
        SRC_BYPASS
    } stage_src_e;

endpackage

// File: rtl/packet_queue_p_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array carries no reset.
module queue_sdp_ram
    import packet_queue_p_pkg::*;
#(
    parameter int unsigned WIDTH  = PQ_PACKET_WIDTH,
    parameter int unsigned ADDR_W = PQ_DEPTH_LOG2
) (
    input  logic              CLK,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (wr_en_i)
            mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i)
            rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/packet_queue_p.sv
// First-word-fall-through packet FIFO: inferred RAM plus a 2-entry prefetch
// stage. Optional RAM bypass into the stage via PACKET_QUEUE_P_BYPASS_EN.
module packet_queue_p
    import packet_queue_p_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = PQ_PACKET_WIDTH,
    parameter int unsigned DEPTH_LOG2   = PQ_DEPTH_LOG2,
    parameter int unsigned AFULL_MARGIN = PQ_AFULL_MARGIN
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    RECEIVE_PC_VALID,
    input  logic [PACKET_WIDTH-1:0] RECEIVE_PC_DATA,
    output logic                    RECEIVE_PC_READY,
    output logic                    SEND_PC_VALID,
    output logic [PACKET_WIDTH-1:0] SEND_PC_DATA,
    input  logic                    SEND_PC_READY,
    output logic [DEPTH_LOG2+1:0]   COUNT,
    output logic                    ALMOST_FULL
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 2;

    logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W-1:0]        occ, occ_next;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    rready_q, rready_d, afull_q, afull_d;
    logic                    pend_q, pend_d;
    logic                    v0_q, v0_d, v1_q, v1_d;
    logic [PACKET_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
    logic [PACKET_WIDTH-1:0] rd_data, push_data;
    logic                    clear, full, in_fire, out_fire, room, bypass, wr_en, rd_en;
    logic [1:0]              held;
    stage_src_e              push_src;

    always_comb begin
        clear    = RST || FLUSH;
        occ      = wptr_q - rptr_q;
        full     = occ[DEPTH_LOG2];
        in_fire  = RECEIVE_PC_VALID && rready_q && !full && !clear;
        out_fire = v0_q && SEND_PC_READY && !clear;
        // A read in flight already owns a stage slot, so count it as held
        held     = 2'(v0_q) + 2'(v1_q) - 2'(out_fire);
        room     = (held + 2'(pend_q)) < 2'd2;
`ifdef PACKET_QUEUE_P_BYPASS_EN
        bypass   = in_fire && (occ == '0) && !pend_q && room;
`else
        bypass   = 1'b0;
`endif
        wr_en    = in_fire && !bypass;
        rd_en    = !clear && (occ != '0) && room;
        occ_next = occ + PTR_W'(wr_en) - PTR_W'(rd_en);

        push_src = SRC_NONE;
        if (pend_q)
            push_src = SRC_RAM;
        else if (bypass)
            push_src = SRC_BYPASS;
        push_data = (push_src == SRC_BYPASS) ? RECEIVE_PC_DATA : rd_data;

        v0_d = v0_q;
        v1_d = v1_q;
        s0_d = s0_q;
        s1_d = s1_q;
        if (out_fire) begin
            v0_d = v1_q;
            s0_d = s1_q;
            v1_d = 1'b0;
        end
        // Pushes land in the first free slot so the head never changes under a stall
        if (push_src != SRC_NONE) begin
            if (!v0_d) begin
                v0_d = 1'b1;
                s0_d = push_data;
            end else begin
                v1_d = 1'b1;
                s1_d = push_data;
            end
        end

        wptr_d   = wptr_q + PTR_W'(wr_en);
        rptr_d   = rptr_q + PTR_W'(rd_en);
        pend_d   = rd_en;
        count_d  = count_q + CNT_W'(in_fire) - CNT_W'(out_fire);
        rready_d = !occ_next[DEPTH_LOG2];
        afull_d  = int'(occ_next) >= int'(DEPTH) - int'(AFULL_MARGIN);

        if (clear) begin
            v0_d     = 1'b0;
            v1_d     = 1'b0;
            s0_d     = '0;
            s1_d     = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            pend_d   = 1'b0;
            count_d  = '0;
            rready_d = 1'b0;
            afull_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        pend_q   <= pend_d;
        count_q  <= count_d;
        rready_q <= rready_d;
        afull_q  <= afull_d;
        v0_q     <= v0_d;
        v1_q     <= v1_d;
        s0_q     <= s0_d;
        s1_q     <= s1_d;
    end

    queue_sdp_ram #(
        .WIDTH  (PACKET_WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .CLK       (CLK),
        .wr_en_i   (wr_en),
        .wr_addr_i (wptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i (RECEIVE_PC_DATA),
        .rd_en_i   (rd_en),
        .rd_addr_i (rptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_data)
    );

    assign RECEIVE_PC_READY = rready_q;
    assign SEND_PC_VALID    = v0_q;
    assign SEND_PC_DATA     = s0_q;
    assign COUNT            = count_q;
    assign ALMOST_FULL      = afull_q;

endmodule
